multicycle_ctrl: RTL and testbench

// Multicycle control sequencer that drives the existing datapath control/field inputs.

---
 rtl/cpu_ctrl_pkg.sv | 83 ++++++++
 rtl/instr_decoder.sv | 78 +++++++
 rtl/multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_ctrl_pkg
// Purpose  : Shared encodings for the LEGv8 multicycle control sequencer:
//            opcode patterns, ALUOp codes, condition codes, flag bit indices,
//            FSM state enum, path/branch classes and the control-bus struct.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  // Opcode patterns, each compared against the top bits of the instruction.
  localparam logic [9:0]  c_op_addi  = 10'b1001000100;   // instr[31:22]
  localparam logic [10:0] c_op_adds  = 11'b10101011000;  // instr[31:21]
  localparam logic [10:0] c_op_subs  = 11'b11101011000;
  localparam logic [10:0] c_op_ldur  = 11'b11111000010;
  localparam logic [10:0] c_op_ldurb = 11'b00111000010;
  localparam logic [10:0] c_op_stur  = 11'b11111000000;
  localparam logic [10:0] c_op_sturb = 11'b00111000000;
  localparam logic [8:0]  c_op_movk  = 9'b111100101;     // instr[31:23]
  localparam logic [8:0]  c_op_movz  = 9'b110100101;
  localparam logic [5:0]  c_op_b     = 6'b000101;        // instr[31:26]
  localparam logic [7:0]  c_op_bcond = 8'b01010100;      // instr[31:24]
  localparam logic [7:0]  c_op_cbz   = 8'b10110100;

  localparam logic [2:0] c_aluop_passb = 3'b000;
  localparam logic [2:0] c_aluop_add   = 3'b010;
  localparam logic [2:0] c_aluop_sub   = 3'b011;

  localparam logic [3:0] c_cond_eq = 4'h0;
  localparam logic [3:0] c_cond_ne = 4'h1;
  localparam logic [3:0] c_cond_ge = 4'hA;
  localparam logic [3:0] c_cond_lt = 4'hB;

  // Bit positions inside the {N,Z,V,C} flag vector.
  localparam int c_flag_n = 3;
  localparam int c_flag_z = 2;
  localparam int c_flag_v = 1;
  localparam int c_flag_c = 0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // State that follows EXEC for a legal instruction.
  typedef enum logic [1:0] {
    PATH_WB  = 2'd0,
    PATH_MEM = 2'd1,
    PATH_BR  = 2'd2
  } path_e;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_COND   = 2'd2,
    BR_CBZ    = 2'd3
  } br_e;

  // Control bus in datapath bit order. regwrite/memread/memwrite here only
  // say the instruction needs the strobe; the top gates them by state.
  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       chooseimm;
    logic       xferbyte;
    logic       choosemovk;
    logic       choosemovz;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
//------------------------------------------------------------------------------
// Module   : instr_decoder
// Purpose  : Combinational opcode decode for the multicycle sequencer.
// Ports    : i_opcode    in  11  instruction bits [31:21]
//            o_ctrl      out     control bus (ctrl_t)
//            o_path      out     state class after EXEC
//            o_br        out     branch kind
//            o_set_flags out  1  instruction updates the flag register
//            o_legal     out  1  opcode recognised
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] i_opcode,
  output ctrl_t       o_ctrl,
  output path_e       o_path,
  output br_e         o_br,
  output logic        o_set_flags,
  output logic        o_legal
);

  always_comb begin
    o_ctrl      = '0;
    o_path      = PATH_WB;
    o_br        = BR_NONE;
    o_set_flags = 1'b0;
    o_legal     = 1'b1;

    if (i_opcode[10:1] == c_op_addi) begin
      o_ctrl.chooseimm = 1'b1;
      o_ctrl.reg2loc   = 1'b1;
      o_ctrl.aluop     = c_aluop_add;
      o_ctrl.regwrite  = 1'b1;
    end else if (i_opcode == c_op_adds || i_opcode == c_op_subs) begin
      o_ctrl.reg2loc   = 1'b1;
      o_ctrl.aluop     = (i_opcode == c_op_subs) ? c_aluop_sub : c_aluop_add;
      o_ctrl.regwrite  = 1'b1;
      o_set_flags      = 1'b1;
    end else if (i_opcode == c_op_ldur || i_opcode == c_op_ldurb) begin
      o_ctrl.alusrc    = 1'b1;
      o_ctrl.memtoreg  = 1'b1;
      o_ctrl.aluop     = c_aluop_add;
      o_ctrl.memread   = 1'b1;
      o_ctrl.regwrite  = 1'b1;
      o_ctrl.xferbyte  = (i_opcode == c_op_ldurb);
      o_path           = PATH_MEM;
    end else if (i_opcode == c_op_stur || i_opcode == c_op_sturb) begin
      o_ctrl.alusrc    = 1'b1;
      o_ctrl.aluop     = c_aluop_add;
      o_ctrl.memwrite  = 1'b1;
      o_ctrl.xferbyte  = (i_opcode == c_op_sturb);
      o_path           = PATH_MEM;
    end else if (i_opcode[10:2] == c_op_movk || i_opcode[10:2] == c_op_movz) begin
      o_ctrl.choosemovk = (i_opcode[10:2] == c_op_movk);
      o_ctrl.choosemovz = (i_opcode[10:2] == c_op_movz);
      o_ctrl.aluop      = c_aluop_passb;
      o_ctrl.regwrite   = 1'b1;
    end else if (i_opcode[10:5] == c_op_b) begin
      o_path = PATH_BR;
      o_br   = BR_UNCOND;
    end else if (i_opcode[10:3] == c_op_bcond) begin
      o_path = PATH_BR;
      o_br   = BR_COND;
    end else if (i_opcode[10:3] == c_op_cbz) begin
      o_ctrl.aluop = c_aluop_passb;
      o_path       = PATH_BR;
      o_br         = BR_CBZ;
    end else begin
      o_legal = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : multicycle_ctrl
// Purpose  : Multicycle LEGv8 control sequencer. Fetches over a req/valid
//            handshake, steps FETCH/DECODE/EXEC/MEM/WB, owns PC, IR and the
//            NZVC flag register, resolves B, B.cond and CBZ.
// Ports    : clk, reset (async active-low)
//            imem_req/imem_addr/imem_rdata/imem_valid  instruction fetch
//            flags              live {N,Z,V,C} from the datapath
//            Rd Rn Rm Daddr9 Imm12 Imm16 Shamt        IR fields
//            Reg2Loc ALUSrc MemToReg ChooseImm xferByte ChooseMovk
//            ChooseMovz ALUOp   steady controls for the current instruction
//            RegWrite MemRead MemWrite                one-cycle strobes
//            pc, halted
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int                   PC_WIDTH = 64,  // must be >= 28
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_valid,
  input  logic [3:0]          flags,
  output logic [4:0]          Rd,
  output logic [4:0]          Rn,
  output logic [4:0]          Rm,
  output logic [8:0]          Daddr9,
  output logic [11:0]         Imm12,
  output logic [15:0]         Imm16,
  output logic [1:0]          Shamt,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                MemRead,
  output logic                ChooseImm,
  output logic                xferByte,
  output logic                ChooseMovk,
  output logic                ChooseMovz,
  output logic [2:0]          ALUOp,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  state_e              r_state;
  logic [31:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic [3:0]          r_flags;
  logic                r_req;
  logic                r_halted;
  logic                r_regwrite;
  logic                r_memread;
  logic                r_memwrite;

  ctrl_t               w_ctrl;
  path_e               w_path;
  br_e                 w_br;
  logic                w_set_flags;
  logic                w_legal;
  logic                w_cond_ok;
  logic                w_taken;
  logic [PC_WIDTH-1:0] w_br_off;
  logic [PC_WIDTH-1:0] w_pc_seq;
  logic                w_unused_flag_c;

  // Decoding the held IR keeps fields/controls steady from DECODE onward;
  // an illegal (or reset) IR decodes to an all-zero control bus.
  instr_decoder u_dec (
    .i_opcode    (r_ir[31:21]),
    .o_ctrl      (w_ctrl),
    .o_path      (w_path),
    .o_br        (w_br),
    .o_set_flags (w_set_flags),
    .o_legal     (w_legal)
  );

  // B.cond tests the stored flags, not the live datapath flags.
  always_comb begin
    w_cond_ok = 1'b0;
    case (r_ir[3:0])
      c_cond_eq: w_cond_ok = r_flags[c_flag_z];
      c_cond_ne: w_cond_ok = !r_flags[c_flag_z];
      c_cond_ge: w_cond_ok = (r_flags[c_flag_n] == r_flags[c_flag_v]);
      c_cond_lt: w_cond_ok = (r_flags[c_flag_n] != r_flags[c_flag_v]);
      default:   w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_br)
      BR_UNCOND: w_taken = 1'b1;
      BR_COND:   w_taken = w_cond_ok;
      BR_CBZ:    w_taken = flags[c_flag_z];
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_br_off = (w_br == BR_UNCOND)
                  ? {{(PC_WIDTH-28){r_ir[25]}}, r_ir[25:0], 2'b00}
                  : {{(PC_WIDTH-21){r_ir[23]}}, r_ir[23:5], 2'b00};

  assign w_pc_seq = r_pc + PC_WIDTH'(4);

  // C is stored with the other flags but no supported branch tests it.
  assign w_unused_flag_c = r_flags[c_flag_c];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_ir       <= '0;
      r_pc       <= RESET_PC;
      r_flags    <= '0;
      r_req      <= 1'b0;
      r_halted   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else begin
      // Strobes are one cycle wide; they are only re-armed on state entry.
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;

      case (r_state)
        S_FETCH: begin
          // Only a response to an outstanding request is accepted.
          if (r_req && imem_valid) begin
            r_ir    <= imem_rdata;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end else begin
            r_req   <= 1'b1;
          end
        end

        S_DECODE: begin
          if (w_legal) begin
            r_state  <= S_EXEC;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end

        S_EXEC: begin
          if (w_set_flags) begin
            r_flags <= flags;
          end
          case (w_path)
            PATH_WB: begin
              r_state    <= S_WB;
              r_regwrite <= 1'b1;
            end
            PATH_MEM: begin
              r_state    <= S_MEM;
              r_memread  <= w_ctrl.memread;
              r_memwrite <= w_ctrl.memwrite;
            end
            default: begin
              r_pc    <= w_taken ? (r_pc + w_br_off) : w_pc_seq;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          if (w_ctrl.regwrite) begin
            r_state    <= S_WB;
            r_regwrite <= 1'b1;
          end else begin
            r_pc    <= w_pc_seq;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_WB: begin
          r_pc    <= w_pc_seq;
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign halted     = r_halted;

  assign RegWrite   = r_regwrite;
  assign MemRead    = r_memread;
  assign MemWrite   = r_memwrite;

  assign Reg2Loc    = w_ctrl.reg2loc;
  assign ALUSrc     = w_ctrl.alusrc;
  assign MemToReg   = w_ctrl.memtoreg;
  assign ChooseImm  = w_ctrl.chooseimm;
  assign xferByte   = w_ctrl.xferbyte;
  assign ChooseMovk = w_ctrl.choosemovk;
  assign ChooseMovz = w_ctrl.choosemovz;
  assign ALUOp      = w_ctrl.aluop;

  assign Rd         = r_ir[4:0];
  assign Rn         = r_ir[9:5];
  assign Rm         = r_ir[20:16];
  assign Daddr9     = r_ir[20:12];
  assign Imm12      = r_ir[21:10];
  assign Imm16      = r_ir[20:5];
  assign Shamt      = r_ir[22:21];

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl. Stimulus queues expected
//            fetch/strobe events; a monitor pops and compares them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [3:0]  flags;
  logic [4:0]  Rd, Rn, Rm;
  logic [8:0]  Daddr9;
  logic [11:0] Imm12;
  logic [15:0] Imm16;
  logic [1:0]  Shamt;
  logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead;
  logic        ChooseImm, xferByte, ChooseMovk, ChooseMovz;
  logic [2:0]  ALUOp;
  logic [63:0] pc;
  logic        halted;

  multicycle_ctrl #(.PC_WIDTH(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .flags(flags),
    .Rd(Rd), .Rn(Rn), .Rm(Rm), .Daddr9(Daddr9), .Imm12(Imm12), .Imm16(Imm16), .Shamt(Shamt),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .ChooseImm(ChooseImm), .xferByte(xferByte),
    .ChooseMovk(ChooseMovk), .ChooseMovz(ChooseMovz), .ALUOp(ALUOp),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // {Reg2Loc,ALUSrc,MemToReg,ChooseImm,xferByte,ChooseMovk,ChooseMovz,ALUOp}
  wire [9:0] ctl = {Reg2Loc, ALUSrc, MemToReg, ChooseImm, xferByte, ChooseMovk, ChooseMovz, ALUOp};
  localparam logic [9:0] CTL_ADDI  = 10'b1001000_010;
  localparam logic [9:0] CTL_SUBS  = 10'b1000000_011;
  localparam logic [9:0] CTL_LDURB = 10'b0110100_010;
  localparam logic [9:0] CTL_STUR  = 10'b0100000_010;
  localparam logic [9:0] CTL_MOVZ  = 10'b0000001_000;

  localparam logic [1:0] K_FETCH = 2'd0, K_RW = 2'd1, K_MR = 2'd2, K_MW = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  dly;   // fetch: cycles since previous fetch (0 = skip); strobe: cycles after fetch
    logic [63:0] addr;
    logic [9:0]  ctl;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fetch = 0;

  task automatic sb_check(input logic [1:0] kind);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got event kind=%0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = q.pop_front();
      if (kind == K_FETCH) begin
        if (e.kind != K_FETCH || imem_addr !== e.addr ||
            (e.dly != 0 && (cyc - last_fetch) != int'(e.dly))) begin
          n_bad++;
          $display("FAIL sb_fetch: got kind=%0d addr=%0h gap=%0d, required kind=%0d addr=%0h gap=%0d",
                   kind, imem_addr, cyc - last_fetch, e.kind, e.addr, e.dly);
        end
        last_fetch = cyc;
      end else begin
        if (e.kind != kind || (cyc - last_fetch) != int'(e.dly) || ctl !== e.ctl || Rd !== e.rd) begin
          n_bad++;
          $display("FAIL sb_strobe: got kind=%0d dly=%0d ctl=%b rd=%0d, required kind=%0d dly=%0d ctl=%b rd=%0d",
                   kind, cyc - last_fetch, ctl, Rd, e.kind, e.dly, e.ctl, e.rd);
        end
      end
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (imem_req && imem_valid) sb_check(K_FETCH);
      if (RegWrite)               sb_check(K_RW);
      if (MemRead)                sb_check(K_MR);
      if (MemWrite)               sb_check(K_MW);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_fetch(input logic [63:0] a, input int d);
    exp_t e;
    e = '{kind: K_FETCH, dly: d[3:0], addr: a, ctl: 10'd0, rd: 5'd0};
    q.push_back(e);
  endtask

  task automatic exp_strobe(input logic [1:0] k, input int d, input logic [9:0] c, input logic [4:0] r);
    exp_t e;
    e = '{kind: k, dly: d[3:0], addr: 64'd0, ctl: c, rd: r};
    q.push_back(e);
  endtask

  // Waits (bounded) for imem_req, stalls, then returns the word for one cycle.
  task automatic issue(input logic [31:0] w, input int stall);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_timeout: got imem_req=0 for 20 cycles, required 1");
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("req_held", imem_req, 1);
      chk("no_strobe_before_valid", {RegWrite, MemRead, MemWrite}, 0);
    end
    imem_rdata = w;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
  endtask

  initial begin
    reset      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    flags      = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", {RegWrite, MemRead, MemWrite}, 0);
    chk("rst_ctl", ctl, 0);
    reset = 1'b1;

    // ADDI X0,X31,#512 with 3 stall cycles
    exp_fetch(64'd0, 0);
    exp_strobe(K_RW, 3, CTL_ADDI, 5'd0);
    issue(32'h910803E0, 3);
    chk("addi_imm12", Imm12, 512);
    chk("addi_rn", Rn, 31);

    // SUBS X5,X31,X30 with N=1 -> flag register 1000
    flags = 4'b1000;
    exp_fetch(64'd4, 4);
    exp_strobe(K_RW, 3, CTL_SUBS, 5'd5);
    issue(32'hEB1E03E5, 0);
    chk("subs_rm", Rm, 30);

    // B.LT -8 at pc=8; live flags cleared so only the stored N!=V makes it taken
    exp_fetch(64'd8, 4);
    issue(32'h54FFFFCB, 0);
    flags = 4'b0000;

    // LDURB X9,[X31,#16] at pc=0
    exp_fetch(64'd0, 3);
    exp_strobe(K_MR, 3, CTL_LDURB, 5'd9);
    exp_strobe(K_RW, 4, CTL_LDURB, 5'd9);
    issue(32'h384103E9, 0);
    chk("ldurb_daddr9", Daddr9, 16);

    // STUR X3,[X2,#8]
    exp_fetch(64'd4, 5);
    exp_strobe(K_MW, 3, CTL_STUR, 5'd3);
    issue(32'hF8008043, 0);

    // MOVZ X7,#0xABCD
    exp_fetch(64'd8, 4);
    exp_strobe(K_RW, 3, CTL_MOVZ, 5'd7);
    issue(32'hD29579A7, 0);
    chk("movz_imm16", Imm16, 16'hABCD);
    chk("movz_shamt", Shamt, 0);

    // CBZ, live Z=0 -> not taken
    exp_fetch(64'd12, 4);
    issue(32'hB4000081, 0);

    // CBZ, Z=1, imm19=0x3FFFF -> 16 + 0xFFFFC
    exp_fetch(64'd16, 3);
    issue(32'hB47FFFE2, 0);
    flags = 4'b0100;

    // CBZ, Z=1, imm19=0x7FFFF (-1) -> pc - 4
    exp_fetch(64'h10000C, 3);
    issue(32'hB4FFFFE2, 0);

    // B back past zero -> pc wraps to 0xFFFF_FFFF_FFFF_FFFC
    exp_fetch(64'h100008, 3);
    issue(32'h17FBFFFD, 0);
    flags = 4'b0000;

    // ADDI at the top of the address space: pc+4 wraps to 0
    exp_fetch(64'hFFFF_FFFF_FFFF_FFFC, 3);
    exp_strobe(K_RW, 3, CTL_ADDI, 5'd0);
    issue(32'h910803E0, 0);

    exp_fetch(64'd0, 4);
    exp_strobe(K_RW, 3, CTL_ADDI, 5'd0);
    issue(32'h910803E0, 0);

    // Illegal word at pc=4 -> halt
    exp_fetch(64'd4, 4);
    issue(32'h00000000, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_pc", pc, 4);
    end

    // Reset out of HALT
    reset = 1'b0;
    @(negedge clk);
    chk("rst_halt_pc", pc, 0);
    chk("rst_halt_flag", halted, 0);
    reset = 1'b1;

    // Reset during EXEC of an ADDI: no write-back strobe may follow
    exp_fetch(64'd0, 0);
    issue(32'h910803E0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_regwrite", RegWrite, 0);
    chk("abort_pc", pc, 0);
    reset = 1'b1;

    // Clean restart after the abort
    exp_fetch(64'd0, 0);
    exp_strobe(K_RW, 3, CTL_MOVZ, 5'd7);
    issue(32'hD29579A7, 0);
    repeat (8) @(negedge clk);
    chk("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
